// File: rtl/pipeline_pkg.sv
// Shared RV32I pipeline definitions: the canonical NOP, default reset vector
// and the fetch-stage state encoding.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        SKID = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, registered output to
// decode, one-entry skid for stalls, and squash/refetch on execute redirects.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        i_clock,
    input  logic        i_nreset,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_valid
);

    fetch_state_t r_state, w_state_next;
    logic [31:0]  r_pc, w_pc_next;
    logic [31:0]  r_drop_addr, w_drop_addr_next;
    logic [31:0]  r_skid_instr, w_skid_instr_next;
    logic [31:0]  r_skid_pc, w_skid_pc_next;
    logic [31:0]  r_instr, w_instr_next;
    logic [31:0]  r_instr_pc, w_instr_pc_next;
    logic         r_instr_valid, w_instr_valid_next;

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_state       <= REQ;
            r_pc          <= RESET_PC;
            r_drop_addr   <= '0;
            r_skid_instr  <= NOP_INSTR;
            r_skid_pc     <= '0;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_drop_addr   <= w_drop_addr_next;
            r_skid_instr  <= w_skid_instr_next;
            r_skid_pc     <= w_skid_pc_next;
            r_instr       <= w_instr_next;
            r_instr_pc    <= w_instr_pc_next;
            r_instr_valid <= w_instr_valid_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_drop_addr_next   = r_drop_addr;
        w_skid_instr_next  = r_skid_instr;
        w_skid_pc_next     = r_skid_pc;
        w_instr_next       = r_instr;
        w_instr_pc_next    = r_instr_pc;
        w_instr_valid_next = r_instr_valid;

        if (i_redirect) begin
            w_pc_next          = i_redirect_pc & ~32'h3;
            w_instr_next       = NOP_INSTR;
            w_instr_valid_next = 1'b0;
            w_skid_instr_next  = NOP_INSTR;
            w_skid_pc_next     = '0;
            // A request still in flight must be drained; an ack this cycle retires it.
            case (r_state)
                REQ: begin
                    if (i_imem_ack) begin
                        w_state_next = REQ;
                    end else begin
                        w_state_next     = DROP;
                        w_drop_addr_next = r_pc;
                    end
                end
                SKID:    w_state_next = REQ;
                DROP:    w_state_next = i_imem_ack ? REQ : DROP;
                default: w_state_next = REQ;
            endcase
        end else begin
            case (r_state)
                REQ: begin
                    if (i_imem_ack) begin
                        w_pc_next = r_pc + 32'd4;
                        if (i_stall && r_instr_valid) begin
                            w_skid_instr_next = i_imem_rdata;
                            w_skid_pc_next    = r_pc;
                            w_state_next      = SKID;
                        end else begin
                            w_instr_next       = i_imem_rdata;
                            w_instr_pc_next    = r_pc;
                            w_instr_valid_next = 1'b1;
                        end
                    end else if (!i_stall) begin
                        w_instr_next       = NOP_INSTR;
                        w_instr_valid_next = 1'b0;
                    end
                end
                SKID: begin
                    if (!i_stall) begin
                        w_instr_next       = r_skid_instr;
                        w_instr_pc_next    = r_skid_pc;
                        w_instr_valid_next = 1'b1;
                        w_skid_instr_next  = NOP_INSTR;
                        w_skid_pc_next     = '0;
                        w_state_next       = REQ;
                    end
                end
                DROP: begin
                    if (i_imem_ack) begin
                        w_state_next = REQ;
                    end
                end
                default: w_state_next = REQ;
            endcase
        end
    end

    // Gated by reset so memory never sees a request while the pipeline is held.
    assign o_imem_req    = i_nreset && (r_state != SKID);
    assign o_imem_addr   = (r_state == DROP) ? r_drop_addr : r_pc;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_instr_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a variable-latency memory, a transaction-level
// reference of the fetch rules, and an in-order delivered-stream check.
module tb_fetch_stage;
    import pipeline_pkg::*;

    logic        clk;
    logic        nreset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;

    int total;
    int bad;

    // Reference model: fetch pointer, killed-request tracking, parked word, output slot.
    logic [31:0] m_pc;
    logic        m_killed;
    logic [31:0] m_kaddr;
    logic        m_parked;
    logic [31:0] m_park_word;
    logic [31:0] m_park_pc;
    logic [31:0] m_word;
    logic [31:0] m_wpc;
    logic        m_valid;
    logic [31:0] exp_next;
    logic        mem_busy;
    int          mem_wait;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .i_clock       (clk),
        .i_nreset      (nreset),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ack    (imem_ack),
        .i_imem_rdata  (imem_rdata),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .o_instr_valid (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0103;
            1:       return 32'hFFFF_FFFC;
            2:       return 32'hFFFF_FFF5;
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        m_pc        = 32'h0;
        m_killed    = 1'b0;
        m_kaddr     = 32'h0;
        m_parked    = 1'b0;
        m_park_word = NOP_INSTR;
        m_park_pc   = 32'h0;
        m_word      = NOP_INSTR;
        m_wpc       = 32'h0;
        m_valid     = 1'b0;
        exp_next    = 32'h0;
        mem_busy    = 1'b0;
        mem_wait    = 0;
    endtask

    // Called at a negedge: compare, drive one cycle of stimulus, advance the model.
    task automatic do_cycle(input int max_lat, input int p_stall, input int p_red);
        logic        st;
        logic        red;
        logic        ack;
        logic [31:0] rpc;
        logic [31:0] rd;
        logic [31:0] tgt;

        check("req", {31'b0, imem_req}, {31'b0, !m_parked});
        if (!m_parked) check("addr", imem_addr, m_killed ? m_kaddr : m_pc);
        check("valid", {31'b0, instr_valid}, {31'b0, m_valid});
        check("instr", instr, m_word);
        if (m_valid) check("instr_pc", instr_pc, m_wpc);

        st  = ($urandom_range(0, 99) < p_stall);
        red = ($urandom_range(0, 99) < p_red);
        rpc = pick_target();
        tgt = rpc & ~32'h3;
        ack = 1'b0;
        rd  = $urandom;
        if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_wait = $urandom_range(0, max_lat);
            end
            if (mem_wait == 0) begin
                ack      = 1'b1;
                rd       = memf(imem_addr);
                mem_busy = 1'b0;
            end else begin
                mem_wait--;
            end
        end
        stall       = st;
        redirect    = red;
        redirect_pc = rpc;
        imem_ack    = ack;
        imem_rdata  = rd;

        // Decode consumes a valid word whenever it is not stalling.
        if (instr_valid && !st) begin
            check("stream_pc", instr_pc, exp_next);
            check("stream_word", instr, memf(instr_pc));
            $display("deliver pc=%08h instr=%08h t=%0t", instr_pc, instr, $time);
            exp_next = instr_pc + 32'd4;
        end
        if (red) exp_next = tgt;

        if (red) begin
            if (!m_parked && !ack && !m_killed) m_kaddr = m_pc;
            m_killed    = !m_parked && !ack;
            m_parked    = 1'b0;
            m_pc        = tgt;
            m_word      = NOP_INSTR;
            m_valid     = 1'b0;
        end else if (m_parked) begin
            if (!st) begin
                m_word   = m_park_word;
                m_wpc    = m_park_pc;
                m_valid  = 1'b1;
                m_parked = 1'b0;
            end
        end else if (m_killed) begin
            if (ack) m_killed = 1'b0;
        end else if (ack) begin
            if (st && m_valid) begin
                m_parked    = 1'b1;
                m_park_word = rd;
                m_park_pc   = m_pc;
            end else begin
                m_word  = rd;
                m_wpc   = m_pc;
                m_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_word  = NOP_INSTR;
            m_valid = 1'b0;
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        nreset      = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        model_reset();

        repeat (2) @(negedge clk);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instr", instr, NOP_INSTR);
        check("rst_instr_pc", instr_pc, 32'h0);

        nreset = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) do_cycle(0, 0, 0);
        for (int k = 0; k < 4; k++)  do_cycle(0, 100, 0);
        for (int k = 0; k < 4; k++)  do_cycle(0, 0, 0);
        for (int k = 0; k < 1500; k++) do_cycle(3, 30, 6);

        // Asynchronous reset while a request is outstanding.
        for (int k = 0; k < 20 && !imem_req; k++) do_cycle(3, 0, 0);
        stall    = 1'b0;
        redirect = 1'b0;
        imem_ack = 1'b0;
        #2;
        nreset = 1'b0;
        #1;
        check("arst_req", {31'b0, imem_req}, 32'h0);
        check("arst_valid", {31'b0, instr_valid}, 32'h0);
        check("arst_instr", instr, NOP_INSTR);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
        #1;
        check("restart_addr", imem_addr, 32'h0);
        for (int k = 0; k < 400; k++) do_cycle(2, 40, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the five-stage RV32I pipeline, directly upstream of the decode/register-read stage. Holds the program counter, issues one outstanding request at a time to instruction memory over a req/ack handshake, and presents a registered instruction word, its PC and a valid flag to decode. Honours decode stalls without losing a returned word, using a one-entry skid register. Handles taken-branch/jump redirects from execute, including redirects that arrive while a memory request is in flight.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- Clock  in  1  rising-edge clock.
- nReset  in  1  asynchronous reset, active low.
- stall  in  1  decode cannot accept a new instruction this cycle; outputs hold.
- redirect  in  1  execute resolved a taken branch/jump; squash and refetch.
- redirect_pc  in  32  redirect target; bits [1:0] are forced to 0 internally.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  32  word address of the request.
- imem_ack  in  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  in  32  instruction word.
- instr  out  32  registered instruction to decode.
- instr_pc  out  32  PC of instr.
- instr_valid  out  1  instr is a real instruction, not a bubble.

## Operation
- States: REQ (request outstanding), SKID (word parked, no request), DROP (killed request awaiting its ack).
- Reset: state REQ; pc=RESET_PC; skid empty; instr=NOP (32'h0000_0013), instr_pc=0, instr_valid=0; imem_req=0 while nReset low.
- REQ: imem_req=1, imem_addr=pc. The address is held stable until ack.
  - ack with stall=0 or instr_valid=0: load instr=rdata, instr_pc=pc, valid=1; pc+=4; stay REQ.
  - ack with stall=1 and instr_valid=1: park {rdata, pc} in skid; pc+=4; go SKID.
  - no ack, stall=0: instr=NOP, valid=0 (bubble).
- SKID: imem_req=0. stall=1: hold everything. stall=0: outputs take skid contents, valid=1, skid empties, go REQ.
- DROP: imem_req=1, imem_addr=the killed address. On ack: discard rdata, go REQ with the current pc. Outputs stay NOP/invalid.
- Redirect has top priority and overrides stall:
  - Always: pc=redirect_pc & ~3, instr=NOP, valid=0, skid cleared.
  - From REQ without ack in the same cycle: go DROP.
  - From REQ with ack in the same cycle: discard rdata, go REQ.
  - From SKID: go REQ.
  - From DROP: stay DROP with the new pc. Only the newest redirect target survives.
- pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- stall never blocks an in-flight ack. The returned word always lands in instr or skid.

## Timing
- imem_ack may arrive in the same cycle as the first imem_req cycle (zero-wait memory) or any later cycle. Memory must not ack when imem_req=0.
- ack in cycle N gives instr/instr_valid updated at edge N+1. The next request address appears from cycle N+1.
- Zero-wait memory with no stall gives one instruction per cycle.
- First request: imem_req rises in the first cycle after nReset deasserts.
- Redirect sampled at edge N: instr_valid=0 from N, and the new address is requested from N (or after the DROP ack). This gives a fixed minimum 1-cycle bubble after redirect with zero-wait memory.
- Asynchronous reset mid-request abandons the request. Memory is required to be reset by the same nReset.

## Structure
- Shared package pipeline_pkg: NOP_INSTR constant, RESET_PC default, fetch_state_t enum {REQ, SKID, DROP}.
- Single module, no sub-modules. The skid register lives inline.

## Test plan
- Reset release, zero-wait memory returning rdata=addr: imem_addr 0,4,8,…; instr_pc 0,4,8 on consecutive cycles; first instr_valid one cycle after first ack.
- stall held 3 cycles while instr_pc=8 is valid and ack for 12 arrives: 12 goes to skid, imem_req=0; after stall drops, instr_pc=12 valid next cycle, then request 16.
- Redirect to 32'h0000_0103 with a 3-cycle-latency memory, request for 20 pending: DROP; ack for 20 discarded; next imem_addr=32'h100; instr_valid=0 until its ack+1.
- Redirect together with stall=1 and a full skid: instr=NOP, valid=0, skid cleared, request to the target issued.
- pc=32'hFFFF_FFFC fetch: next imem_addr=0.
- nReset asserted mid-request: outputs immediately instr=NOP, valid=0, imem_req=0; after release, fetch restarts at RESET_PC.
